// File: rtl/icdf_grng_ctrl.sv
// icdf_grng_ctrl: sequencer and output buffer for the ICDF Gaussian RNG datapath.
// Drives en_icdf with a PIPE_LAT-cycle warm-up and captures valid gauss_in
// samples into a first-word fall-through FIFO. The FIFO is drained through a
// valid/ready stream. Runs are fixed-length bursts, or continuous when
// burst_len is 0. A full FIFO pauses the pipeline until it drains to LOW_WM.
// Optional feature macro: GRNG_STATS_EN adds the stat_drop/stat_out counters.
module icdf_grng_ctrl #(
   parameter int PIPE_LAT = 7,
   parameter int DEPTH    = 16,
   parameter int LOW_WM   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] burst_len,
   output logic        en_icdf,
   input  logic [15:0] gauss_in,
   output logic [15:0] sample_data,
   output logic        sample_valid,
   input  logic        sample_ready,
   output logic        busy,
   output logic        done
`ifdef GRNG_STATS_EN
   ,
   output logic [31:0] stat_drop,
   output logic [31:0] stat_out
`endif
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int WCW = $clog2(PIPE_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WARM,
      S_RUN,
      S_PAUSE,
      S_DRAIN
   } state_t;

   state_t          state, state_nxt;
   logic [15:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count, count_nxt;
   logic [WCW-1:0]  warm_cnt;
   logic [15:0]     wr_cnt, burst_q;
   logic            wr, rd, fill, burst_end;

   // FIFO handshake, occupancy update and RUN-state event decode.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves
      // it unassigned and no latch is inferred.
      sample_valid = (count != '0);
      sample_data  = sample_valid ? mem[rd_ptr] : 16'h0000;
      rd           = sample_valid && sample_ready;
      wr           = (state == S_RUN) && ((count != CW'(DEPTH)) || rd);
      count_nxt    = count;
      case ({wr, rd})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
      // Full with no read pending: pause. A read at full keeps the run going.
      fill      = (count_nxt == CW'(DEPTH)) && !rd;
      burst_end = wr && (burst_q != 16'h0000) && ((wr_cnt + 16'd1) == burst_q);
   end

   // Next-state logic; stop outranks burst-end and full transitions.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_WARM;
         S_WARM:  if (stop) state_nxt = S_DRAIN;
                  else if (warm_cnt == WCW'(PIPE_LAT)) state_nxt = S_RUN;
         S_RUN:   if (stop || burst_end) state_nxt = S_DRAIN;
                  else if (fill) state_nxt = S_PAUSE;
         S_PAUSE: if (stop) state_nxt = S_DRAIN;
                  else if (count <= CW'(LOW_WM)) state_nxt = S_WARM;
         S_DRAIN: if (count == '0) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register plus registered control outputs derived from next state.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (rst) begin
         state   <= S_IDLE;
         en_icdf <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         en_icdf <= (state_nxt == S_WARM) || (state_nxt == S_RUN);
         busy    <= (state_nxt != S_IDLE);
         done    <= (state == S_DRAIN) && (state_nxt == S_IDLE);
      end
   end

   // Warm-up counter: 1 on WARM entry, counts up to PIPE_LAT while in WARM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         warm_cnt <= '0;
      end else if (state_nxt == S_WARM) begin
         warm_cnt <= (state == S_WARM) ? warm_cnt + WCW'(1) : WCW'(1);
      end else begin
         warm_cnt <= '0;
      end
   end

   // Burst length latch and write counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_q <= 16'h0000;
         wr_cnt  <= 16'h0000;
      end else if (state == S_IDLE && start) begin
         burst_q <= burst_len;
         wr_cnt  <= 16'h0000;
      end else if (wr) begin
         wr_cnt  <= wr_cnt + 16'd1;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (rd) rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
      end
   end

   // FIFO storage.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is not reset; the count gates sample_data, so
      // stale contents are never visible.
      if (wr) mem[wr_ptr] <= gauss_in;
   end

`ifdef GRNG_STATS_EN
   logic drop_evt;

   // In-flight samples are lost when RUN ends by pause or stop, not burst end.
   always_comb begin
      drop_evt = (state == S_RUN) && (stop || (fill && !burst_end));
   end

   // Saturating statistics counters, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_drop <= 32'h0;
         stat_out  <= 32'h0;
      end else begin
         if (drop_evt)
            stat_drop <= (stat_drop > (32'hFFFF_FFFF - 32'(PIPE_LAT))) ?
                         32'hFFFF_FFFF : stat_drop + 32'(PIPE_LAT);
         if (rd && (stat_out != 32'hFFFF_FFFF))
            stat_out <= stat_out + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icdf_grng_ctrl.sv
// Testbench for icdf_grng_ctrl. A behavioural top_icdf model feeds gauss_in;
// every valid sample it emits is pushed to a scoreboard, and a negedge monitor
// pops and compares on every consumer transfer.
module tb_icdf_grng_ctrl;

   localparam int PIPE_LAT = 7;
   localparam int DEPTH    = 16;
   localparam int LOW_WM   = 4;

   logic        clk = 1'b0;
   logic        rst, start, stop, sample_ready;
   logic [15:0] burst_len, gauss_in, sample_data;
   logic        en_icdf, sample_valid, busy, done;
`ifdef GRNG_STATS_EN
   logic [31:0] stat_drop, stat_out;
`endif

   always #5 clk = ~clk;

   icdf_grng_ctrl #(.PIPE_LAT(PIPE_LAT), .DEPTH(DEPTH), .LOW_WM(LOW_WM)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .burst_len(burst_len),
      .en_icdf(en_icdf), .gauss_in(gauss_in), .sample_data(sample_data),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .busy(busy), .done(done)
`ifdef GRNG_STATS_EN
      , .stat_drop(stat_drop), .stat_out(stat_out)
`endif
   );

   // top_icdf model: PIPE_LAT-stage pipeline, flushed while en_icdf is low.
   logic [15:0]         pipe_d [PIPE_LAT];
   logic [PIPE_LAT-1:0] pipe_v = '0;
   int                  seq = 1;
   logic                gauss_valid;

   function automatic logic [15:0] mk(input int s);
      return 16'(s * 2749 + 32769);
   endfunction

   always @(posedge clk) begin
      if (en_icdf) begin
         for (int i = PIPE_LAT - 1; i > 0; i--) pipe_d[i] <= pipe_d[i-1];
         pipe_d[0] <= mk(seq);
         pipe_v    <= {pipe_v[PIPE_LAT-2:0], 1'b1};
         seq       <= seq + 1;
      end else begin
         pipe_v <= '0;
      end
   end

   assign gauss_valid = en_icdf && pipe_v[PIPE_LAT-1];
   assign gauss_in    = gauss_valid ? pipe_d[PIPE_LAT-1] : 16'h0000;

   // Scoreboard and counters.
   logic [15:0] sb [$];
   int passed = 0, total = 0;
   int xfer_cnt = 0, xfer_total = 0, done_cnt = 0, expect_drop = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: compare on transfer, then enqueue the sample about to be written.
   always @(negedge clk) begin
      if (!rst) begin
         if (sample_valid && sample_ready) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("sample_data", sample_data, sb.pop_front());
            xfer_cnt++;
            xfer_total++;
         end
         if (gauss_valid) sb.push_back(gauss_in);
         if (done) done_cnt++;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [15:0] len);
      burst_len = len;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Counts en_icdf-high cycles from now until the FIFO presents a freshly
   // written sample after having been empty.
   task automatic measure_warm(output int n);
      bit seen_empty = 1'b0;
      n = 0;
      for (int i = 0; i < 60; i++) begin
         if (!sample_valid) seen_empty = 1'b1;
         if (seen_empty && sample_valid) break;
         if (en_icdf) n++;
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit ok;
      bit any;
      int n;

      rst = 1'b1; start = 1'b0; stop = 1'b0; sample_ready = 1'b0; burst_len = 16'd0;
      #1;
      check("rst_en_icdf", 32'(en_icdf), 32'd0);
      check("rst_valid", 32'(sample_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_data", 32'(sample_data), 32'd0);
`ifdef GRNG_STATS_EN
      check("rst_stat_drop", stat_drop, 32'd0);
      check("rst_stat_out", stat_out, 32'd0);
`endif
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Test 1: reset during RUN with 5 samples buffered.
      pulse_start(16'd0);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (sb.size() == 5) begin ok = 1'b1; break; end
      end
      check("t1_five_buffered", 32'(ok), 32'd1);
      rst = 1'b1;
      sb.delete();
      xfer_total = 0;
      expect_drop = 0;
      #1;
      check("t1_en_icdf", 32'(en_icdf), 32'd0);
      check("t1_valid", 32'(sample_valid), 32'd0);
      check("t1_busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      any = 1'b0;
      repeat (20) begin
         tick();
         if (busy || en_icdf || sample_valid) any = 1'b1;
      end
      check("t1_stays_idle", 32'(any), 32'd0);

      // Test 2: burst of 10 with the consumer always ready.
      xfer_cnt = 0; done_cnt = 0; sample_ready = 1'b1;
      pulse_start(16'd10);
      check("t2_en_rise", 32'(en_icdf), 32'd1);
      check("t2_busy", 32'(busy), 32'd1);
      measure_warm(n);
      check("t2_warm_cycles", 32'(n), 32'(PIPE_LAT + 1));
      wait_done(100, ok);
      check("t2_done_seen", 32'(ok), 32'd1);
      check("t2_xfers", 32'(xfer_cnt), 32'd10);
      check("t2_busy_at_done", 32'(busy), 32'd0);
      tick();
      check("t2_done_single", 32'(done), 32'd0);
      check("t2_busy_after", 32'(busy), 32'd0);
      check("t2_done_cnt", 32'(done_cnt), 32'd1);
      check("t2_sb_empty", 32'(sb.size()), 32'd0);

      // Test 3: continuous mode, fill and pause, restart at the low watermark.
      xfer_cnt = 0; sample_ready = 1'b0;
      pulse_start(16'd0);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!en_icdf) begin ok = 1'b1; break; end
      end
      check("t3_paused", 32'(ok), 32'd1);
      check("t3_fifo_full", 32'(sb.size()), 32'(DEPTH));
      check("t3_valid_full", 32'(sample_valid), 32'd1);
      repeat (5) tick();
      check("t3_still_paused", 32'(en_icdf), 32'd0);
      check("t3_busy_pause", 32'(busy), 32'd1);
      sample_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (en_icdf) begin ok = 1'b1; break; end
      end
      check("t3_restart", 32'(ok), 32'd1);
      check("t3_xfers_to_wm", 32'(xfer_cnt), 32'(DEPTH - LOW_WM + 1));
      measure_warm(n);
      check("t3_rewarm_cycles", 32'(n), 32'(PIPE_LAT + 1));
      repeat (30) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      expect_drop += 14;
      wait_done(100, ok);
      check("t3_done_seen", 32'(ok), 32'd1);
      tick();
      check("t3_sb_empty", 32'(sb.size()), 32'd0);

      // Test 4a: stop three cycles into WARM.
      xfer_cnt = 0;
      pulse_start(16'd0);
      repeat (2) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t4a_en_low", 32'(en_icdf), 32'd0);
      check("t4a_busy_drain", 32'(busy), 32'd1);
      check("t4a_no_done_yet", 32'(done), 32'd0);
      tick();
      check("t4a_done", 32'(done), 32'd1);
      tick();
      check("t4a_done_clear", 32'(done), 32'd0);
      check("t4a_idle", 32'(busy), 32'd0);
      check("t4a_no_xfers", 32'(xfer_cnt), 32'd0);

      // Test 4b: stop in RUN with 6 buffered plus the same-cycle write.
      xfer_cnt = 0; sample_ready = 1'b0;
      pulse_start(16'd0);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (sb.size() == 6) begin ok = 1'b1; break; end
      end
      check("t4b_six_buffered", 32'(ok), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      expect_drop += 7;
      check("t4b_en_low", 32'(en_icdf), 32'd0);
      sample_ready = 1'b1;
      wait_done(100, ok);
      check("t4b_done_seen", 32'(ok), 32'd1);
      check("t4b_xfers", 32'(xfer_cnt), 32'd7);
      tick();

      // Test 5: start while busy is ignored; start+stop in IDLE starts a run.
      xfer_cnt = 0; done_cnt = 0;
      pulse_start(16'd5);
      repeat (3) tick();
      burst_len = 16'd20;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(100, ok);
      check("t5_done_seen", 32'(ok), 32'd1);
      check("t5_xfers", 32'(xfer_cnt), 32'd5);
      any = 1'b0;
      repeat (10) begin
         tick();
         if (busy) any = 1'b1;
      end
      check("t5_no_restart", 32'(any), 32'd0);
      check("t5_done_cnt", 32'(done_cnt), 32'd1);
      xfer_cnt = 0;
      burst_len = 16'd3;
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      check("t5_pair_busy", 32'(busy), 32'd1);
      check("t5_pair_en", 32'(en_icdf), 32'd1);
      wait_done(100, ok);
      check("t5_pair_done", 32'(ok), 32'd1);
      check("t5_pair_xfers", 32'(xfer_cnt), 32'd3);
      tick();

`ifdef GRNG_STATS_EN
      // Test 6: statistics since the mid-run reset.
      check("t6_stat_drop", stat_drop, 32'(expect_drop));
      check("t6_stat_out", stat_out, 32'(xfer_total));
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
